// File: rtl/sc_gameevent_tracker_if.sv
// Event bus between the game state machine (master) and the game-event tracker (slave):
// frog datapath inputs, handshake strobes and the tracker's event outputs.
interface sc_gameevent_tracker_if;
  logic [3:0] FrogRow_In;
  logic [3:0] FrogCol_In;
  logic       Collision_InHigh;
  logic [3:0] Level_In;
  logic       SetFrog_InHigh;
  logic       ResetPoint_InHigh;
  logic       WinF_OutLow;
  logic       WinL_OutHigh;
  logic       Lose_OutHigh;
  logic [3:0] NestMask_Out;
  logic [6:0] TimerSec_Out;

  modport master (
    output FrogRow_In, FrogCol_In, Collision_InHigh, Level_In, SetFrog_InHigh, ResetPoint_InHigh,
    input  WinF_OutLow, WinL_OutHigh, Lose_OutHigh, NestMask_Out, TimerSec_Out
  );

  modport slave (
    input  FrogRow_In, FrogCol_In, Collision_InHigh, Level_In, SetFrog_InHigh, ResetPoint_InHigh,
    output WinF_OutLow, WinL_OutHigh, Lose_OutHigh, NestMask_Out, TimerSec_Out
  );
endinterface

// File: rtl/sc_gameevent_tracker.sv
// Game-event tracker: raises WinF/WinL/Lose for the game state machine and tracks filled nests.
// Optional per-life countdown enabled by defining SC_GAMEEVENT_TIMER_EN.
module sc_gameevent_tracker #(
  parameter logic [3:0]  NEST_ROW     = 4'd12,
  parameter logic [3:0]  START_ROW    = 4'd0,
  parameter logic [15:0] NEST_COLS    = 16'hD951,
  parameter logic [6:0]  LIFE_SECONDS = 7'd60
`ifdef SC_GAMEEVENT_TIMER_EN
  , parameter int unsigned TICK_DIV   = 50_000_000
`endif
) (
  input  logic                 SC_STATEMACHINEGAME_CLOCK_50,
  input  logic                 SC_STATEMACHINEGAME_RESET_InHigh,
  sc_gameevent_tracker_if.slave ev_bus
);

  typedef enum logic [2:0] {IDLE, PLAY, NEST_REQ, LEVEL_DONE, DEAD} state_t;

  state_t     state_reg, state_next;
  logic [3:0] mask_reg, mask_next;
  logic [1:0] nest_idx_reg, nest_idx_next;
  logic       winf_reg, winl_reg, lose_reg;
  logic       winf_next, winl_next, lose_next;
  logic [3:0] col_hit, free_hit, mask_set;
  logic [1:0] free_idx;
  logic       level_restart, level_load, timer_zero;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nest
      assign col_hit[gi] = (ev_bus.FrogCol_In == NEST_COLS[4*gi +: 4]);
    end
  endgenerate

  assign free_hit      = col_hit & ~mask_reg;
  assign mask_set      = mask_reg | (4'b0001 << nest_idx_reg);
  assign level_restart = (ev_bus.Level_In <= 4'd3);
  assign level_load    = ev_bus.Level_In inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd9};

  // Lowest-numbered free nest wins if two nests share a column.
  always_comb begin
    free_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (free_hit[i]) free_idx = 2'(i);
    end
  end

  always_comb begin
    state_next    = state_reg;
    mask_next     = mask_reg;
    nest_idx_next = nest_idx_reg;
    case (state_reg)
      IDLE: begin
        if (ev_bus.FrogRow_In == START_ROW && level_restart) state_next = PLAY;
      end
      PLAY: begin
        if (ev_bus.Collision_InHigh || timer_zero) begin
          state_next = DEAD;
        end else if (ev_bus.FrogRow_In == NEST_ROW) begin
          if (|free_hit) begin
            state_next    = NEST_REQ;
            nest_idx_next = free_idx;
          end else begin
            state_next = DEAD;
          end
        end
      end
      NEST_REQ: begin
        if (ev_bus.SetFrog_InHigh) begin
          mask_next  = mask_set;
          state_next = (mask_set == 4'hF) ? LEVEL_DONE : IDLE;
        end
      end
      LEVEL_DONE: begin
        if (level_load) begin
          mask_next  = 4'd0;
          state_next = IDLE;
        end
      end
      DEAD:    state_next = DEAD;
      default: state_next = IDLE;
    endcase
    // A point reset preempts any handshake completing in the same cycle.
    if (ev_bus.ResetPoint_InHigh) begin
      state_next = IDLE;
      mask_next  = level_restart ? 4'd0 : mask_reg;
    end
    winf_next = (state_next != NEST_REQ);
    winl_next = (state_next == LEVEL_DONE);
    lose_next = (state_next == DEAD);
  end

  always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50 or posedge SC_STATEMACHINEGAME_RESET_InHigh) begin
    if (SC_STATEMACHINEGAME_RESET_InHigh) begin
      state_reg    <= IDLE;
      mask_reg     <= 4'd0;
      nest_idx_reg <= 2'd0;
      winf_reg     <= 1'b1;
      winl_reg     <= 1'b0;
      lose_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mask_reg     <= mask_next;
      nest_idx_reg <= nest_idx_next;
      winf_reg     <= winf_next;
      winl_reg     <= winl_next;
      lose_reg     <= lose_next;
    end
  end

`ifdef SC_GAMEEVENT_TIMER_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_reg, presc_next;
  logic [6:0]    timer_reg, timer_next;

  always_comb begin
    presc_next = presc_reg;
    timer_next = timer_reg;
    if (state_reg == IDLE && state_next == PLAY) begin
      presc_next = '0;
      timer_next = LIFE_SECONDS;
    end else if (state_reg == PLAY) begin
      if (presc_reg == PW'(TICK_DIV - 1)) begin
        presc_next = '0;
        if (timer_reg != 7'd0) timer_next = timer_reg - 7'd1;
      end else begin
        presc_next = presc_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50 or posedge SC_STATEMACHINEGAME_RESET_InHigh) begin
    if (SC_STATEMACHINEGAME_RESET_InHigh) begin
      presc_reg <= '0;
      timer_reg <= LIFE_SECONDS;
    end else begin
      presc_reg <= presc_next;
      timer_reg <= timer_next;
    end
  end

  assign timer_zero          = (timer_reg == 7'd0);
  assign ev_bus.TimerSec_Out = timer_reg;
`else
  assign timer_zero          = 1'b0;
  assign ev_bus.TimerSec_Out = LIFE_SECONDS;
`endif

  assign ev_bus.WinF_OutLow  = winf_reg;
  assign ev_bus.WinL_OutHigh = winl_reg;
  assign ev_bus.Lose_OutHigh = lose_reg;
  assign ev_bus.NestMask_Out = mask_reg;

endmodule

// File: tb/tb_sc_gameevent_tracker.sv
// Bench for sc_gameevent_tracker: directed scenarios then random stimulus, every cycle compared
// against a flag-based reference model of the game-event rules.
`timescale 1ns/1ps
module tb_sc_gameevent_tracker;
`ifdef SC_GAMEEVENT_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
  localparam int L_SEC    = 2;
  localparam int T_DIV    = 4;
`else
  localparam bit TIMER_EN = 1'b0;
  localparam int L_SEC    = 60;
  localparam int T_DIV    = 1;
`endif
  localparam int NEST_ROW  = 12;
  localparam int START_ROW = 0;

  int nest_col [4] = '{1, 5, 9, 13};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  sc_gameevent_tracker_if bus();

`ifdef SC_GAMEEVENT_TIMER_EN
  sc_gameevent_tracker #(.LIFE_SECONDS(7'(L_SEC)), .TICK_DIV(T_DIV)) dut (
    .SC_STATEMACHINEGAME_CLOCK_50    (clk),
    .SC_STATEMACHINEGAME_RESET_InHigh(rst),
    .ev_bus                          (bus)
  );
`else
  sc_gameevent_tracker dut (
    .SC_STATEMACHINEGAME_CLOCK_50    (clk),
    .SC_STATEMACHINEGAME_RESET_InHigh(rst),
    .ev_bus                          (bus)
  );
`endif

  always #10 clk = ~clk;

  // Reference model: which event is pending, expressed as independent flags.
  logic [3:0] m_mask;
  bit         m_play, m_won, m_dead;
  int         m_req;
  int         m_ticks;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_timer();
    int t;
    if (!TIMER_EN) return L_SEC;
    t = L_SEC - (m_ticks / T_DIV);
    return (t < 0) ? 0 : t;
  endfunction

  task automatic model_reset();
    m_mask  = 4'd0;
    m_play  = 1'b0;
    m_won   = 1'b0;
    m_dead  = 1'b0;
    m_req   = -1;
    m_ticks = 0;
  endtask

  task automatic model_step();
    int tnow;
    int hit;
    tnow = m_timer();
    if (m_play) m_ticks++;
    if (bus.ResetPoint_InHigh) begin
      m_play = 1'b0; m_won = 1'b0; m_dead = 1'b0; m_req = -1;
      if (bus.Level_In <= 3) m_mask = 4'd0;
    end else if (m_req >= 0) begin
      if (bus.SetFrog_InHigh) begin
        m_mask[m_req] = 1'b1;
        m_req = -1;
        if (m_mask == 4'hF) m_won = 1'b1;
      end
    end else if (m_won) begin
      if (bus.Level_In inside {4, 5, 6, 7, 9}) begin
        m_won  = 1'b0;
        m_mask = 4'd0;
      end
    end else if (m_dead) begin
      m_dead = 1'b1;
    end else if (m_play) begin
      if (bus.Collision_InHigh || (TIMER_EN && tnow == 0)) begin
        m_play = 1'b0;
        m_dead = 1'b1;
      end else if (bus.FrogRow_In == NEST_ROW) begin
        hit = -1;
        for (int i = 3; i >= 0; i--)
          if (bus.FrogCol_In == nest_col[i] && !m_mask[i]) hit = i;
        m_play = 1'b0;
        if (hit >= 0) m_req = hit;
        else m_dead = 1'b1;
      end
    end else if (bus.FrogRow_In == START_ROW && bus.Level_In <= 3) begin
      m_play  = 1'b1;
      m_ticks = 0;
    end
  endtask

  task automatic compare_all();
    check_val("winf", bus.WinF_OutLow, (m_req >= 0) ? 0 : 1);
    check_val("winl", bus.WinL_OutHigh, m_won);
    check_val("lose", bus.Lose_OutHigh, m_dead);
    check_val("mask", bus.NestMask_Out, m_mask);
    check_val("timer", bus.TimerSec_Out, m_timer());
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic go_nest(input int col, input int hold);
    bus.FrogRow_In = 4'(START_ROW);
    cycle();
    bus.FrogRow_In = 4'(NEST_ROW);
    bus.FrogCol_In = 4'(col);
    cycle();
    check_val("nest_req", bus.WinF_OutLow, 0);
    repeat (hold) cycle();
    check_val("nest_hold", bus.WinF_OutLow, 0);
    bus.SetFrog_InHigh = 1'b1;
    bus.FrogRow_In     = 4'(START_ROW);
    cycle();
    bus.SetFrog_InHigh = 1'b0;
    check_val("nest_ack", bus.WinF_OutLow, 1);
    $display("nest col=%0d mask=%b winl=%0d", col, bus.NestMask_Out, bus.WinL_OutHigh);
  endtask

  initial begin
    bus.FrogRow_In        = 4'd0;
    bus.FrogCol_In        = 4'd0;
    bus.Collision_InHigh  = 1'b0;
    bus.Level_In          = 4'd0;
    bus.SetFrog_InHigh    = 1'b0;
    bus.ResetPoint_InHigh = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check_val("rst_timer", bus.TimerSec_Out, L_SEC);
    rst = 1'b0;
    $display("reset released");

    cycle();
    check_val("play_winf", bus.WinF_OutLow, 1);
    check_val("play_lose", bus.Lose_OutHigh, 0);

    go_nest(1, 3);
    check_val("first_mask", bus.NestMask_Out, 4'b0001);
    go_nest(5, 0);
    go_nest(9, 0);
    go_nest(13, 0);
    check_val("level_done", bus.WinL_OutHigh, 1);
    repeat (10) cycle();
    check_val("level_hold", bus.WinL_OutHigh, 1);
    bus.Level_In = 4'd5;
    cycle();
    check_val("level_release", bus.WinL_OutHigh, 0);
    check_val("level_mask", bus.NestMask_Out, 0);
    bus.Level_In = 4'd0;
    $display("level cleared");

    go_nest(1, 0);
    bus.FrogRow_In = 4'(START_ROW);
    cycle();
    bus.FrogRow_In       = 4'(NEST_ROW);
    bus.FrogCol_In       = 4'd1;
    bus.Collision_InHigh = 1'b1;
    cycle();
    check_val("coll_lose", bus.Lose_OutHigh, 1);
    check_val("coll_winf", bus.WinF_OutLow, 1);
    bus.Collision_InHigh  = 1'b0;
    bus.FrogRow_In        = 4'(START_ROW);
    bus.Level_In          = 4'd8;
    bus.ResetPoint_InHigh = 1'b1;
    cycle();
    check_val("lose_release", bus.Lose_OutHigh, 0);
    check_val("lose_mask", bus.NestMask_Out, 4'b0001);
    bus.ResetPoint_InHigh = 1'b0;
    bus.Level_In          = 4'd0;
    $display("collision lose then point reset");

    cycle();
    bus.FrogRow_In = 4'd5;
    if (TIMER_EN) begin
      for (int i = 0; i < 40; i++) begin
        cycle();
        if (bus.Lose_OutHigh) break;
      end
      check_val("timeout_lose", bus.Lose_OutHigh, 1);
      check_val("timeout_timer", bus.TimerSec_Out, 0);
    end else begin
      repeat (100) cycle();
      check_val("no_timeout", bus.Lose_OutHigh, 0);
    end
    bus.ResetPoint_InHigh = 1'b1;
    bus.FrogRow_In        = 4'(START_ROW);
    cycle();
    bus.ResetPoint_InHigh = 1'b0;
    check_val("restart_mask", bus.NestMask_Out, 0);
    $display("timer phase done");

    cycle();
    bus.FrogRow_In = 4'(NEST_ROW);
    bus.FrogCol_In = 4'd5;
    cycle();
    check_val("pre_areset", bus.WinF_OutLow, 0);
    #5;
    rst = 1'b1;
    #1;
    check_val("areset_winf", bus.WinF_OutLow, 1);
    check_val("areset_mask", bus.NestMask_Out, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.FrogRow_In = 4'(START_ROW);
    $display("async reset mid-handshake");

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: bus.FrogRow_In = 4'(START_ROW);
        4, 5, 6:    bus.FrogRow_In = 4'(NEST_ROW);
        default:    bus.FrogRow_In = 4'($urandom_range(1, 11));
      endcase
      bus.FrogCol_In        = ($urandom_range(0, 3) != 0) ? 4'(nest_col[$urandom_range(0, 3)])
                                                          : 4'($urandom_range(0, 15));
      bus.Collision_InHigh  = ($urandom_range(0, 15) == 0);
      bus.SetFrog_InHigh    = ($urandom_range(0, 2) == 0);
      bus.ResetPoint_InHigh = ($urandom_range(0, 19) == 0);
      bus.Level_In          = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9)) : 4'd0;
      cycle();
    end
    $display("random phase done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sc_gameevent_tracker.md
# sc_gameevent_tracker

Game-event generator that drives the three event inputs of the game state machine: nest reached (WinF, active-low), level cleared (WinL, active-high) and frog lost (Lose, active-high). It watches frog position, lane collision and a per-life countdown, and handshakes with the state machine's SET_FrogGame, RESET_FromGame_Point and Level_Out outputs. It also tracks which of the four nests are filled. It sits between the frog/lane datapath and the game state machine.

## Interface
- NEST_ROW, 4'd12: frog row holding the nests.
- START_ROW, 4'd0: frog spawn row; used to re-arm detection.
- NEST_COLS, 16'h_D951: four packed 4-bit nest columns; nest i = NEST_COLS[4i+3:4i].
- LIFE_SECONDS, 7'd60: countdown reload value.
- TICK_DIV, 50_000_000: clock cycles per countdown second.

Ports:
- SC_STATEMACHINEGAME_CLOCK_50  in  1  system clock, 50 MHz.
- SC_STATEMACHINEGAME_RESET_InHigh  in  1  asynchronous, active-high reset.
- FrogRow_In  in  4  current frog row.
- FrogCol_In  in  4  current frog column.
- Collision_InHigh  in  1  frog overlaps a hazard.
- Level_In  in  4  Level_Out from the state machine.
- SetFrog_InHigh  in  1  SET_FrogGame from the state machine (nest acknowledged).
- ResetPoint_InHigh  in  1  RESET_FromGame_Point from the state machine.
- WinF_OutLow  out  1  nest request, active-low.
- WinL_OutHigh  out  1  level cleared.
- Lose_OutHigh  out  1  frog lost.
- NestMask_Out  out  4  filled nests; bit i = nest i.
- TimerSec_Out  out  7  remaining seconds.

## Operation
- All outputs are registered. Reset values: WinF_OutLow=1, WinL_OutHigh=0, Lose_OutHigh=0, NestMask_Out=0, TimerSec_Out=LIFE_SECONDS, state=IDLE, prescaler=0.
- **IDLE**
  - All events are deasserted.
  - Go to PLAY when ResetPoint_InHigh=0, FrogRow_In=START_ROW and Level_In≤3.
  - Reload the timer and prescaler when entering PLAY.
- **PLAY**, evaluated every cycle in priority order:
  1. If Collision_InHigh=1, or the timer is 0, go to DEAD.
  2. If FrogRow_In=NEST_ROW and the column matches nest i with NestMask[i]=0, go to NEST_REQ and latch i.
  3. If FrogRow_In=NEST_ROW and the column matches no free nest (a filled nest or a gap), go to DEAD.
- **NEST_REQ**
  - WinF_OutLow=0, held until SetFrog_InHigh=1 is sampled.
  - On that cycle set NestMask[i].
  - If the mask becomes 4'hF, go to LEVEL_DONE; otherwise go to IDLE.
- **LEVEL_DONE**
  - WinL_OutHigh=1, held until Level_In ∈ {4,5,6,7,9} (load screens).
  - Then clear NestMask and go to IDLE.
- **DEAD**
  - Lose_OutHigh=1, held until ResetPoint_InHigh=1 is sampled, then go to IDLE.
  - NestMask is kept.
- **ResetPoint_InHigh=1 in any state** forces IDLE.
  - If Level_In≤3 (level restart), NestMask is cleared.
  - If Level_In=8 (lose screen), NestMask is kept.
- **Timer**
  - The prescaler counts 0..TICK_DIV-1 in PLAY only.
  - When it wraps, TimerSec decrements.
  - TimerSec saturates at 0 and never wraps.
  - The timer and prescaler freeze in all other states.

## Timing
- Event latency: condition sampled in PLAY at edge N → output changes at edge N+1.
- At most one event output is active at any time.
- Release latency: acknowledge sampled at edge N → output deasserted at edge N+1.
- Same cycle as a nest hit:
  - Collision: Lose wins.
  - Timer reaching 0: Lose wins.
- SetFrog_InHigh or Level_In changes outside the states that wait for them are ignored.
- Asynchronous reset mid-handshake: all event outputs return to their inactive values immediately.

## Configuration
- SC_GAMEEVENT_TIMER_EN
  - Defined: the countdown and prescaler are present, and timer expiry causes Lose.
  - Undefined: no prescaler, TimerSec_Out is constant LIFE_SECONDS, and Lose is caused only by collision or a wrong nest column.

## Test plan
- Reset; then Level_In=0, frog at START_ROW → IDLE→PLAY in 1 cycle; all outputs inactive; TimerSec_Out=60.
- Frog at row 12, column 1:
  - Expected: WinF_OutLow=0 next cycle, held.
  - Then pulse SetFrog_InHigh for 1 cycle → NestMask_Out=4'b0001; WinF_OutLow=1 on the following cycle.
- Fill nests at columns 1, 5, 9, 13 in sequence:
  - Expected: WinL_OutHigh=1 after the 4th SetFrog_InHigh.
  - Hold Level_In=0 for 10 cycles → WinL_OutHigh stays 1.
  - Set Level_In=5 → WinL_OutHigh=0 and NestMask_Out=0.
- NestMask=4'b0001; frog at row 12, column 1 with Collision_InHigh=1 in the same cycle:
  - Expected: Lose_OutHigh=1, WinF_OutLow stays 1.
  - Then ResetPoint_InHigh=1 with Level_In=8 → Lose_OutHigh=0 and NestMask_Out=4'b0001 retained.
- With SC_GAMEEVENT_TIMER_EN, TICK_DIV=4, LIFE_SECONDS=2, frog idle in PLAY:
  - Expected: TimerSec_Out 2→1→0 every 4 cycles, then Lose_OutHigh=1.
  - Without the macro, Lose_OutHigh stays 0 for 100 cycles.
- Assert reset while WinF_OutLow=0 → WinF_OutLow=1 immediately, NestMask_Out=0.
